cand_packer_64: RTL and testbench
=================================

CAND_PACKER_64 -- requirements
Module: cand_packer_64

Interface
REQ-001 SHALL have parameter WORD_MAX_LEN, default 64, max candidate length in bytes.
REQ-002 SHALL have parameter BEATS_MSB, default `MSB((WORD_MAX_LEN-1)/8), beat-counter MSB.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: CLK in, rst_n in.
REQ-004 SHALL have port CLK  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active low.
REQ-006 SHALL have port din  in  8  byte from generator word storage, valid 1 cycle after rd_addr.
REQ-007 SHALL have port rd_addr  out  `MSB(WORD_MAX_LEN-1)+1  byte read address.
REQ-008 SHALL have port empty  in  1  generator storage holds no candidate.
REQ-009 SHALL have port set_empty  out  1  1-cycle pulse releasing generator storage.
REQ-010 SHALL have ports word_len_in `MSB(WORD_MAX_LEN)+1, word_id_in 16, gen_id_in 32, pkt_id_in 16, gen_end_in 1, all inputs, valid while empty=0.
REQ-011 SHALL have port dout  out  64  packed candidate beat.
REQ-012 SHALL have ports dout_valid out 1, dout_rd_en in 1, dout_last out 1 (final beat of candidate).
REQ-013 SHALL have ports word_len, word_id, gen_id, pkt_id, gen_end, all outputs of the input widths, stable while dout_valid=1.

Function
REQ-014 SHALL implement FSM IDLE, LATCH, FILL, OUT, RELEASE.
REQ-015 IDLE: on empty=0, SHALL register all *_in header inputs and move to LATCH.
REQ-016 LATCH: SHALL set rd_addr=0, clear byte index, and move to FILL.
REQ-017 FILL: SHALL issue one rd_addr per cycle, rd_addr incrementing from 0, and place byte k at dout[8*(k%8)+7 : 8*(k%8)], with 1-cycle read latency.
REQ-018 FILL SHALL end a beat after 8 bytes or after byte word_len-1, whichever is first, then move to OUT.
REQ-019 OUT: dout_valid=1; beat transfers on the cycle with dout_valid & dout_rd_en; dout_last=1 iff no bytes remain.
REQ-020 dout and dout_last SHALL hold unchanged while dout_valid=1 and dout_rd_en=0.
REQ-021 Number of beats SHALL be ceil(word_len/8); word_len=0 or gen_end=1 SHALL yield exactly one beat with dout_last=1.
REQ-022 set_empty SHALL pulse for exactly one cycle once the final byte is captured, which may be before the final beat is accepted; the pulse SHALL occur once per candidate.
REQ-023 After the last beat transfers, the FSM SHALL go to RELEASE for 1 cycle, then IDLE; empty SHALL NOT be sampled again before IDLE.
REQ-024 dout_rd_en while dout_valid=0 SHALL be ignored.
REQ-025 For word_len=WORD_MAX_LEN, rd_addr SHALL stop at WORD_MAX_LEN-1 with no wrap.
REQ-026 With dout_rd_en held high, the first beat of a len>=8 candidate SHALL be valid within 10 cycles of empty falling.

Reset
REQ-027 With rst_n=0: FSM=IDLE; rd_addr, dout, header outputs = 0; dout_valid, dout_last, set_empty = 0.
REQ-028 Reset mid-candidate SHALL abandon the candidate without a set_empty pulse.
REQ-029 The first candidate after rst_n rises SHALL be packed normally.

Configuration
REQ-030 Macro CAND_PACKER_ZERO_PAD_EN defined: bytes of the final beat at index >= word_len SHALL be 0x00, and word_len=0 beat = 64'h0.
REQ-031 Macro CAND_PACKER_ZERO_PAD_EN undefined: those bytes SHALL retain prior beat contents (don't-care for the consumer); saves the mask logic.

Verification
REQ-032 len=3 "abc", dout_rd_en=1 -> one beat, dout[23:0]=24'h636261, dout_last=1, one set_empty pulse; with ZERO_PAD_EN, dout[63:24]=0.
REQ-033 len=17, bytes 0x00..0x10 -> 3 beats: 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, low byte 0x10; dout_last only on beat 3.
REQ-034 len=16, dout_rd_en=0 for 20 cycles -> beat 1 held stable; set_empty not pulsed before the second beat's bytes are captured; 2 beats total.
REQ-035 gen_end_in=1, word_len_in=5 -> single beat, gen_end=1, dout_last=1, set_empty pulses once.
REQ-036 rst_n=0 during FILL of a len=24 candidate -> all outputs 0 next cycle, no set_empty; after release, the next candidate is packed correctly.
REQ-037 len=WORD_MAX_LEN (64) back-to-back with len=1 -> 8 beats, rd_addr max 63, then 1 beat; header outputs switch only after the RELEASE state.

Source files
------------

// File: rtl/cand_packer_64.sv
// Packs a byte-serial candidate word from generator storage into 64-bit beats plus header.
// Optional CAND_PACKER_ZERO_PAD_EN clears unused bytes of the final beat.

`ifndef MSB
`define MSB(x) ($clog2((x)+1)-1)
`endif

module cand_packer_64 #(
    parameter int WORD_MAX_LEN = 64,
    parameter int BEATS_MSB    = `MSB((WORD_MAX_LEN-1)/8)
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic [7:0]                    din,
    output logic [`MSB(WORD_MAX_LEN-1):0] rd_addr,
    input  logic                          empty,
    output logic                          set_empty,
    input  logic [`MSB(WORD_MAX_LEN):0]   word_len_in,
    input  logic [15:0]                   word_id_in,
    input  logic [31:0]                   gen_id_in,
    input  logic [15:0]                   pkt_id_in,
    input  logic                          gen_end_in,
    output logic [63:0]                   dout,
    output logic                          dout_valid,
    input  logic                          dout_rd_en,
    output logic                          dout_last,
    output logic [`MSB(WORD_MAX_LEN):0]   word_len,
    output logic [15:0]                   word_id,
    output logic [31:0]                   gen_id,
    output logic [15:0]                   pkt_id,
    output logic                          gen_end
);

    localparam int AW = `MSB(WORD_MAX_LEN-1)+1;
    localparam int LW = `MSB(WORD_MAX_LEN)+1;

    typedef enum logic [2:0] {IDLE, LATCH, FILL, OUT, RELEASE} state_t;

    state_t             state, nxt;
    logic               rd_vld, cap_vld, last_r;
    logic [LW-1:0]      cap_idx, len_eff, issue_nxt;
    logic [BEATS_MSB:0] beat, beat_nxt;
    logic [2:0]         lane;
    logic               issue_ok, cap_fire, cap_final, beat_end;

    // Reads never run past the current beat, so din is never lost while OUT stalls.
    always_comb begin
        len_eff   = (gen_end && word_len > LW'(8)) ? LW'(8) : word_len;
        issue_nxt = LW'(rd_addr) + LW'(1);
        issue_ok  = rd_vld && (issue_nxt < len_eff) && (issue_nxt[2:0] != 3'd0);
        lane      = cap_idx[2:0];
        cap_fire  = (state == FILL) && cap_vld;
        cap_final = cap_fire && (cap_idx == len_eff - LW'(1));
        beat_end  = cap_fire && (cap_final || lane == 3'd7);
        beat_nxt  = beat + (BEATS_MSB+1)'(1);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (!empty) nxt = LATCH;
            LATCH:   nxt = (len_eff == '0) ? OUT : FILL;
            FILL:    if (beat_end) nxt = OUT;
            OUT:     if (dout_rd_en) nxt = last_r ? RELEASE : FILL;
            RELEASE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign dout_valid = (state == OUT);
    assign dout_last  = dout_valid && last_r;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            rd_vld    <= 1'b0;
            cap_vld   <= 1'b0;
            cap_idx   <= '0;
            beat      <= '0;
            last_r    <= 1'b0;
            set_empty <= 1'b0;
            dout      <= '0;
            word_len  <= '0;
            word_id   <= '0;
            gen_id    <= '0;
            pkt_id    <= '0;
            gen_end   <= 1'b0;
        end else begin
            set_empty <= 1'b0;
            cap_vld   <= rd_vld;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        word_len <= word_len_in;
                        word_id  <= word_id_in;
                        gen_id   <= gen_id_in;
                        pkt_id   <= pkt_id_in;
                        gen_end  <= gen_end_in;
                        rd_addr  <= '0;
                        rd_vld   <= 1'b1;
                        beat     <= '0;
                        last_r   <= 1'b0;
                    end
                end
                LATCH: begin
                    cap_idx <= '0;
                    if (issue_ok) rd_addr <= rd_addr + AW'(1);
                    else          rd_vld  <= 1'b0;
                    if (len_eff == '0) begin
                        last_r    <= 1'b1;
                        set_empty <= 1'b1;
`ifdef CAND_PACKER_ZERO_PAD_EN
                        dout      <= '0;
`endif
                    end
                end
                FILL: begin
                    if (issue_ok) rd_addr <= rd_addr + AW'(1);
                    else          rd_vld  <= 1'b0;
                    if (cap_fire) begin
                        cap_idx <= cap_idx + LW'(1);
                        for (int unsigned i = 0; i < 8; i++) begin
                            if (i == 32'(lane))
                                dout[8*i +: 8] <= din;
`ifdef CAND_PACKER_ZERO_PAD_EN
                            else if (cap_final && i > 32'(lane))
                                dout[8*i +: 8] <= '0;
`endif
                        end
                        if (cap_final) begin
                            last_r    <= 1'b1;
                            set_empty <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (dout_rd_en && !last_r) begin
                        beat    <= beat_nxt;
                        rd_addr <= AW'({beat_nxt, 3'b000});
                        rd_vld  <= 1'b1;
                    end
                end
                RELEASE: last_r <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cand_packer_64.sv
// Randomized scoreboard bench for cand_packer_64: a behavioural beat model feeds a queue,
// an independent monitor drives dout_rd_en and checks every transferred beat.

module tb_cand_packer_64;

    localparam int LW = 7;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    din = '0;
    logic [5:0]    rd_addr;
    logic          empty = 1'b1;
    logic          set_empty;
    logic [LW-1:0] word_len_in = '0;
    logic [15:0]   word_id_in = '0;
    logic [31:0]   gen_id_in = '0;
    logic [15:0]   pkt_id_in = '0;
    logic          gen_end_in = 1'b0;
    logic [63:0]   dout;
    logic          dout_valid;
    logic          dout_rd_en = 1'b0;
    logic          dout_last;
    logic [LW-1:0] word_len;
    logic [15:0]   word_id;
    logic [31:0]   gen_id;
    logic [15:0]   pkt_id;
    logic          gen_end;

    cand_packer_64 #(.WORD_MAX_LEN(64)) dut (
        .CLK(CLK), .rst_n(rst_n), .din(din), .rd_addr(rd_addr),
        .empty(empty), .set_empty(set_empty),
        .word_len_in(word_len_in), .word_id_in(word_id_in), .gen_id_in(gen_id_in),
        .pkt_id_in(pkt_id_in), .gen_end_in(gen_end_in),
        .dout(dout), .dout_valid(dout_valid), .dout_rd_en(dout_rd_en), .dout_last(dout_last),
        .word_len(word_len), .word_id(word_id), .gen_id(gen_id), .pkt_id(pkt_id), .gen_end(gen_end)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [64];
    always @(posedge CLK) din <= mem[rd_addr];

    typedef struct {
        logic [63:0] data;
        logic [63:0] mask;
        logic        last;
        logic [63:0] hdr;
        logic [7:0]  lg;
    } beat_t;

    beat_t sb[$];
    int    pass_cnt = 0;
    int    chk_cnt = 0;
    int    se_cnt = 0;
    int    stall_mode = 0;   // 0 random, 1 hold low, 2 hold high

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: effective length, ceil(len/8) beats, byte k in lane k%8.
    task automatic push_model(input int len, input logic ge);
        int eff, nb;
        beat_t bt;
        eff = (ge && len > 8) ? 8 : len;
        nb  = (eff == 0) ? 1 : (eff + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            bt.data = '0;
            bt.mask = '0;
            for (int k = 8*b; k < 8*b + 8 && k < eff; k++) begin
                bt.data[8*(k%8) +: 8] = mem[k];
                bt.mask[8*(k%8) +: 8] = 8'hFF;
            end
`ifdef CAND_PACKER_ZERO_PAD_EN
            bt.mask = '1;
`endif
            bt.last = (b == nb - 1);
            bt.hdr  = {word_id_in, pkt_id_in, gen_id_in};
            bt.lg   = {word_len_in, ge};
            sb.push_back(bt);
        end
    endtask

    task automatic start_cand(input int len, input logic ge, input int fill, input bit model);
        @(negedge CLK);
        for (int k = 0; k < 64; k++) begin
            if (fill == 0)      mem[k] = 8'($urandom);
            else if (fill == 1) mem[k] = 8'(k);
        end
        word_len_in = LW'(len);
        word_id_in  = 16'($urandom);
        gen_id_in   = $urandom;
        pkt_id_in   = 16'($urandom);
        gen_end_in  = ge;
        if (model) push_model(len, ge);
        empty = 1'b0;
    endtask

    task automatic finish_cand(output int lat);
        bit got;
        got = 0;
        lat = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge CLK);
            if (dout_valid && lat == 0) lat = n;
            if (set_empty) begin
                got = 1;
                break;
            end
        end
        empty = 1'b1;
        check("set_empty_seen", 64'(got), 64'd1);
    endtask

    task automatic run_cand(input int len, input logic ge, input int fill);
        int lat;
        start_cand(len, ge, fill, 1'b1);
        finish_cand(lat);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge CLK);
            if (sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        check("drain", 64'(done), 64'd1);
        repeat (4) @(negedge CLK);
    endtask

    // Monitor: owns dout_rd_en, pops expected beats on each transfer.
    logic        held_v = 1'b0;
    logic [63:0] held_d;
    logic        held_l;
    initial begin
        beat_t e;
        forever begin
            @(negedge CLK);
            case (stall_mode)
                0:       dout_rd_en = ($urandom_range(0, 3) != 0);
                1:       dout_rd_en = 1'b0;
                default: dout_rd_en = 1'b1;
            endcase
            #1;
            if (!rst_n) begin
                held_v = 1'b0;
                continue;
            end
            if (set_empty) se_cnt++;
            if (held_v && dout_valid) begin
                check("hold_dout", dout, held_d);
                check("hold_last", 64'(dout_last), 64'(held_l));
            end
            held_v = dout_valid && !dout_rd_en;
            held_d = dout;
            held_l = dout_last;
            if (dout_valid && dout_rd_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(dout_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("dout", dout & e.mask, e.data & e.mask);
                    check("dout_last", 64'(dout_last), 64'(e.last));
                    check("hdr_ids", {word_id, pkt_id, gen_id}, e.hdr);
                    check("hdr_len_end", 64'({word_len, gen_end}), 64'(e.lg));
                    check("set_empty_count", 64'(se_cnt), e.last ? 64'd1 : 64'd0);
                    if (e.last) se_cnt = 0;
                end
            end
        end
    end

    initial begin
        int lat;
        for (int k = 0; k < 64; k++) mem[k] = '0;

        repeat (3) @(negedge CLK);
        #1;
        check("rst_dout", dout, 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_last", 64'(dout_last), 64'd0);
        check("rst_set_empty", 64'(set_empty), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_hdr", {word_id, pkt_id, gen_id}, 64'd0);
        check("rst_len", 64'({word_len, gen_end}), 64'd0);
        @(negedge CLK);
        rst_n = 1'b1;

        stall_mode = 2;
        mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
        run_cand(3, 1'b0, 2);
        drain();
        run_cand(17, 1'b0, 1);
        drain();

        // Long stall on the first beat of a two-beat candidate.
        stall_mode = 1;
        start_cand(16, 1'b0, 0, 1'b1);
        repeat (20) @(negedge CLK);
        #2;
        check("stall_valid", 64'(dout_valid), 64'd1);
        check("stall_no_set_empty", 64'(se_cnt), 64'd0);
        stall_mode = 0;
        finish_cand(lat);
        drain();

        run_cand(5, 1'b1, 0);
        drain();

        stall_mode = 2;
        start_cand(8, 1'b0, 0, 1'b1);
        finish_cand(lat);
        check("first_beat_latency_ok", 64'(lat >= 1 && lat <= 10), 64'd1);
        drain();

        // Reset during FILL of a 24-byte candidate; nothing is expected from it.
        stall_mode = 0;
        start_cand(24, 1'b0, 0, 1'b0);
        repeat (5) @(negedge CLK);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(dout_valid), 64'd0);
        check("mid_rst_set_empty", 64'(set_empty), 64'd0);
        check("mid_rst_dout", dout, 64'd0);
        check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
        check("mid_rst_hdr", {word_id, pkt_id, gen_id}, 64'd0);
        check("mid_rst_no_pulse", 64'(se_cnt), 64'd0);
        empty = 1'b1;
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        run_cand(10, 1'b0, 0);
        drain();

        run_cand(64, 1'b0, 1);
        run_cand(1, 1'b0, 0);
        drain();
        run_cand(0, 1'b0, 0);
        run_cand(0, 1'b1, 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            run_cand($urandom_range(0, 64), ($urandom_range(0, 7) == 0), 0);
            if ($urandom_range(0, 3) == 0) stall_mode = $urandom_range(0, 2) == 0 ? 2 : 0;
        end
        stall_mode = 0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
